// File: rtl/axi_dram_resp_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_dram_resp_if
//  Description : Bundle of the LSU <-> DRAM-responder AXI-style channels
//                (AW, W, B, AR, R). The master modport is the LSU side and
//                the slave modport is the memory responder side. The clock
//                and reset are not part of the bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface axi_dram_resp_if;
    // Write address channel
    logic [7:0]  lsu_axi_awid;
    logic [9:0]  lsu_axi_awaddr;
    logic [7:0]  lsu_axi_awlen;
    logic [2:0]  lsu_axi_awsize;
    logic [1:0]  lsu_axi_awburst;
    logic [2:0]  lsu_axi_awstr;
    logic        lsu_axi_awvld;
    logic [11:0] lsu_axi_oram_addr;
    logic        axi_lsu_awrdy;
    // Write data channel
    logic [63:0] lsu_axi_wdata;
    logic [7:0]  lsu_axi_wstrb;
    logic        lsu_axi_wlast;
    logic        lsu_axi_wvld;
    logic        axi_lsu_wrdy;
    // Write response channel
    logic        axi_lsu_bid;
    logic [1:0]  axi_lsu_bresp;
    logic        axi_lsu_bvld;
    logic [11:0] axi_lsu_resp_oram_addr;
    logic        lsu_axi_brdy;
    // Read address channel
    logic [7:0]  lsu_axi_arid;
    logic [9:0]  lsu_axi_araddr;
    logic [7:0]  lsu_axi_arlen;
    logic [2:0]  lsu_axi_arsize;
    logic [1:0]  lsu_axi_arburst;
    logic [2:0]  lsu_axi_arstr;
    logic        lsu_axi_arvld;
    logic        axi_lsu_arrdy;
    // Read data channel
    logic [7:0]  axi_lsu_rid;
    logic [63:0] axi_lsu_rdata;
    logic [1:0]  axi_lsu_rresp;
    logic        axi_lsu_rlast;
    logic        axi_lsu_rvld;
    logic        lsu_axi_rrdy;

    modport master (
        output lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awsize,
               lsu_axi_awburst, lsu_axi_awstr, lsu_axi_awvld, lsu_axi_oram_addr,
               lsu_axi_wdata, lsu_axi_wstrb, lsu_axi_wlast, lsu_axi_wvld,
               lsu_axi_brdy,
               lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
               lsu_axi_arburst, lsu_axi_arstr, lsu_axi_arvld, lsu_axi_rrdy,
        input  axi_lsu_awrdy, axi_lsu_wrdy, axi_lsu_bid, axi_lsu_bresp,
               axi_lsu_bvld, axi_lsu_resp_oram_addr, axi_lsu_arrdy,
               axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast,
               axi_lsu_rvld
    );

    modport slave (
        input  lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awsize,
               lsu_axi_awburst, lsu_axi_awstr, lsu_axi_awvld, lsu_axi_oram_addr,
               lsu_axi_wdata, lsu_axi_wstrb, lsu_axi_wlast, lsu_axi_wvld,
               lsu_axi_brdy,
               lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
               lsu_axi_arburst, lsu_axi_arstr, lsu_axi_arvld, lsu_axi_rrdy,
        output axi_lsu_awrdy, axi_lsu_wrdy, axi_lsu_bid, axi_lsu_bresp,
               axi_lsu_bvld, axi_lsu_resp_oram_addr, axi_lsu_arrdy,
               axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast,
               axi_lsu_rvld
    );
endinterface
`default_nettype wire

// File: rtl/axi_dram_resp.sv
`default_nettype none
// ============================================================================
//  Module      : axi_dram_resp
//  Description : AXI-style single-port memory responder (64-bit words,
//                MEM_WORDS deep) for the LSU DRAM side. Independent write
//                (AW/W/B) and read (AR/R) engines, one burst in flight each.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset (clears memory)
//                bus    - axi_dram_resp_if.slave, all channel signals
//  Options     : AXI_DRAM_RESP_BOUND_CHK_EN - INCR bursts running past the
//                last word are flagged SLVERR; their writes are dropped and
//                their reads return zero. Undefined: such bursts wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_dram_resp #(
    parameter int MEM_WORDS = 128
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    axi_dram_resp_if.slave      bus
);
    localparam int         IDXW        = $clog2(MEM_WORDS);
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    // Next word pointer: INCR steps and wraps, every other burst type holds.
    function automatic logic [IDXW-1:0] next_ptr(input logic [IDXW-1:0] p,
                                                 input logic [1:0]      burst);
        if (burst != BURST_INCR)        return p;
        if (int'(p) == MEM_WORDS - 1)   return '0;
        return p + 1'b1;
    endfunction

    logic [63:0]     mem_q [MEM_WORDS];
    logic            mem_we;

    logic            rst_done_q, rst_done_d;
    w_state_e        w_state_q, w_state_d;
    logic            bid_q, bid_d;
    logic [11:0]     oram_q, oram_d;
    logic [IDXW-1:0] wptr_q, wptr_d;
    logic [7:0]      wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]      wburst_q, wburst_d;
    logic            werr_q, werr_d, wsup_q, wsup_d;

    r_state_e        r_state_q, r_state_d;
    logic [7:0]      rid_q, rid_d;
    logic [IDXW-1:0] rptr_q, rptr_d;
    logic [7:0]      rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]      rburst_q, rburst_d;
    logic            rerr_q, rerr_d, rsup_q, rsup_d;
    logic [63:0]     rdata_q, rdata_d;

    logic [IDXW-1:0] aw_idx, ar_idx, r_next;
    logic            aw_oob, ar_oob, w_last;

    assign aw_idx = bus.lsu_axi_awaddr[3 +: IDXW];
    assign ar_idx = bus.lsu_axi_araddr[3 +: IDXW];

`ifdef AXI_DRAM_RESP_BOUND_CHK_EN
    assign aw_oob = (bus.lsu_axi_awburst == BURST_INCR) &&
                    (int'(aw_idx) + int'(bus.lsu_axi_awlen) >= MEM_WORDS);
    assign ar_oob = (bus.lsu_axi_arburst == BURST_INCR) &&
                    (int'(ar_idx) + int'(bus.lsu_axi_arlen) >= MEM_WORDS);
`else
    assign aw_oob = 1'b0;
    assign ar_oob = 1'b0;
`endif

    // Address-channel fields that carry no meaning for this responder.
    logic unused_bits;
    assign unused_bits = ^{bus.lsu_axi_awstr, bus.lsu_axi_arstr, bus.lsu_axi_awid[7:1],
                           bus.lsu_axi_awaddr[2:0], bus.lsu_axi_araddr[2:0]};

    // ------------------------------------------------------------------ write
    always_comb begin
        rst_done_d = 1'b1;
        w_state_d  = w_state_q;
        bid_d      = bid_q;
        oram_d     = oram_q;
        wptr_d     = wptr_q;
        wlen_d     = wlen_q;
        wcnt_d     = wcnt_q;
        wburst_d   = wburst_q;
        werr_d     = werr_q;
        wsup_d     = wsup_q;
        mem_we     = 1'b0;
        w_last     = (wcnt_q == wlen_q);
        case (w_state_q)
            W_IDLE: begin
                if (bus.lsu_axi_awvld && rst_done_q) begin
                    bid_d     = bus.lsu_axi_awid[0];
                    oram_d    = bus.lsu_axi_oram_addr;
                    wptr_d    = aw_idx;
                    wlen_d    = bus.lsu_axi_awlen;
                    wburst_d  = bus.lsu_axi_awburst;
                    wcnt_d    = '0;
                    wsup_d    = aw_oob;
                    werr_d    = (bus.lsu_axi_awsize != 3'd3) || bus.lsu_axi_awburst[1] || aw_oob;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (bus.lsu_axi_wvld) begin
                    mem_we = !wsup_q;
                    // wlast must coincide exactly with the beat where cnt==len.
                    if (bus.lsu_axi_wlast != w_last) werr_d = 1'b1;
                    wcnt_d = wcnt_q + 8'd1;
                    wptr_d = next_ptr(wptr_q, wburst_q);
                    if (w_last) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.lsu_axi_brdy) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ------------------------------------------------------------------- read
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        rptr_d    = rptr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rburst_d  = rburst_q;
        rerr_d    = rerr_q;
        rsup_d    = rsup_q;
        rdata_d   = rdata_q;
        r_next    = next_ptr(rptr_q, rburst_q);
        case (r_state_q)
            R_IDLE: begin
                if (bus.lsu_axi_arvld && rst_done_q) begin
                    rid_d     = bus.lsu_axi_arid;
                    rlen_d    = bus.lsu_axi_arlen;
                    rburst_d  = bus.lsu_axi_arburst;
                    rcnt_d    = '0;
                    rptr_d    = ar_idx;
                    rsup_d    = ar_oob;
                    rerr_d    = (bus.lsu_axi_arsize != 3'd3) || bus.lsu_axi_arburst[1] || ar_oob;
                    // mem_q is sampled before any same-edge write lands.
                    rdata_d   = ar_oob ? 64'd0 : mem_q[ar_idx];
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (bus.lsu_axi_rrdy) begin
                    if (rcnt_q == rlen_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        rcnt_d  = rcnt_q + 8'd1;
                        rptr_d  = r_next;
                        rdata_d = rsup_q ? 64'd0 : mem_q[r_next];
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // -------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q <= 1'b0;
            w_state_q  <= W_IDLE;
            bid_q      <= 1'b0;
            oram_q     <= '0;
            wptr_q     <= '0;
            wlen_q     <= '0;
            wcnt_q     <= '0;
            wburst_q   <= '0;
            werr_q     <= 1'b0;
            wsup_q     <= 1'b0;
            r_state_q  <= R_IDLE;
            rid_q      <= '0;
            rptr_q     <= '0;
            rlen_q     <= '0;
            rcnt_q     <= '0;
            rburst_q   <= '0;
            rerr_q     <= 1'b0;
            rsup_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rst_done_q <= rst_done_d;
            w_state_q  <= w_state_d;
            bid_q      <= bid_d;
            oram_q     <= oram_d;
            wptr_q     <= wptr_d;
            wlen_q     <= wlen_d;
            wcnt_q     <= wcnt_d;
            wburst_q   <= wburst_d;
            werr_q     <= werr_d;
            wsup_q     <= wsup_d;
            r_state_q  <= r_state_d;
            rid_q      <= rid_d;
            rptr_q     <= rptr_d;
            rlen_q     <= rlen_d;
            rcnt_q     <= rcnt_d;
            rburst_q   <= rburst_d;
            rerr_q     <= rerr_d;
            rsup_q     <= rsup_d;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (bus.lsu_axi_wstrb[b]) mem_q[wptr_q][8*b +: 8] <= bus.lsu_axi_wdata[8*b +: 8];
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.axi_lsu_awrdy          = rst_done_q && (w_state_q == W_IDLE);
    assign bus.axi_lsu_wrdy           = (w_state_q == W_DATA);
    assign bus.axi_lsu_bvld           = (w_state_q == W_RESP);
    assign bus.axi_lsu_bresp          = ((w_state_q == W_RESP) && werr_q) ? RESP_SLVERR : RESP_OKAY;
    assign bus.axi_lsu_bid            = bid_q;
    assign bus.axi_lsu_resp_oram_addr = oram_q;
    assign bus.axi_lsu_arrdy          = rst_done_q && (r_state_q == R_IDLE);
    assign bus.axi_lsu_rvld           = (r_state_q == R_DATA);
    assign bus.axi_lsu_rlast          = (r_state_q == R_DATA) && (rcnt_q == rlen_q);
    assign bus.axi_lsu_rresp          = ((r_state_q == R_DATA) && rerr_q) ? RESP_SLVERR : RESP_OKAY;
    assign bus.axi_lsu_rid            = rid_q;
    assign bus.axi_lsu_rdata          = rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_dram_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_dram_resp
//  Description : Self-checking bench for axi_dram_resp. Directed scenarios
//                followed by randomized write/read pairs, all checked against
//                a word-array memory model. Honours AXI_DRAM_RESP_BOUND_CHK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_dram_resp;
    localparam int MEM_WORDS = 128;
    localparam int BOUND     = 60;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    axi_dram_resp_if bus ();

    axi_dram_resp #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] model [MEM_WORDS];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({bus.axi_lsu_awrdy, bus.axi_lsu_wrdy, bus.axi_lsu_bid, bus.axi_lsu_bresp,
                     bus.axi_lsu_bvld, bus.axi_lsu_resp_oram_addr, bus.axi_lsu_arrdy,
                     bus.axi_lsu_rid, bus.axi_lsu_rdata, bus.axi_lsu_rresp,
                     bus.axi_lsu_rlast, bus.axi_lsu_rvld});
    endfunction

    // ---------------------------------------------------------- reference model
    function automatic bit fmt_err(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'd3) || burst[1];
    endfunction

    function automatic bit out_of_bounds(input logic [9:0] addr, input logic [7:0] len,
                                         input logic [1:0] burst);
`ifdef AXI_DRAM_RESP_BOUND_CHK_EN
        return (burst == 2'b01) && (int'(addr[9:3]) + int'(len) >= MEM_WORDS);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int nxt(input int idx, input logic [1:0] burst);
        return (burst == 2'b01) ? (idx + 1) % MEM_WORDS : idx;
    endfunction

    task automatic fill(input int n, input bit rand_strb);
        for (int b = 0; b < n; b++) begin
            wd[b] = {$urandom, $urandom};
            ws[b] = rand_strb ? 8'($urandom) : 8'hFF;
        end
    endtask

    // ------------------------------------------------------------ write burst
    task automatic axi_write(input logic [7:0] id, input logic [9:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input logic [11:0] tag,
                             input int last_at, input int gap_max);
        int   idx = int'(addr[9:3]);
        bit   sup = out_of_bounds(addr, len, burst);
        logic [1:0] eresp = (fmt_err(size, burst) || sup || (last_at != int'(len))) ? 2'b10 : 2'b00;
        int   t;
        bus.lsu_axi_awid      = id;
        bus.lsu_axi_awaddr    = addr;
        bus.lsu_axi_awlen     = len;
        bus.lsu_axi_awburst   = burst;
        bus.lsu_axi_awsize    = size;
        bus.lsu_axi_awstr     = 3'($urandom);
        bus.lsu_axi_oram_addr = tag;
        bus.lsu_axi_awvld     = 1'b1;
        t = 0;
        while (!bus.axi_lsu_awrdy && t < BOUND) begin step(); t++; end
        check("aw_wait", 128'(t < BOUND), 128'(1));
        step();
        bus.lsu_axi_awvld = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            bus.lsu_axi_wdata = wd[b];
            bus.lsu_axi_wstrb = ws[b];
            bus.lsu_axi_wlast = (b == last_at);
            bus.lsu_axi_wvld  = 1'b1;
            t = 0;
            while (!bus.axi_lsu_wrdy && t < BOUND) begin step(); t++; end
            check("w_wait", 128'(t < BOUND), 128'(1));
            step();
            if (!sup) begin
                for (int k = 0; k < 8; k++)
                    if (ws[b][k]) model[idx][8*k +: 8] = wd[b][8*k +: 8];
            end
            idx = nxt(idx, burst);
            bus.lsu_axi_wvld  = 1'b0;
            bus.lsu_axi_wlast = 1'b0;
            if (gap_max > 0 && b < int'(len)) repeat ($urandom_range(gap_max, 0)) step();
        end
        check("b_vld_latency", 128'(bus.axi_lsu_bvld), 128'(1));
        t = 0;
        while (!bus.axi_lsu_bvld && t < BOUND) begin step(); t++; end
        repeat ($urandom_range(2, 0)) begin
            check("b_resp_hold", 128'(bus.axi_lsu_bresp), 128'(eresp));
            step();
        end
        check("b_vld", 128'(bus.axi_lsu_bvld), 128'(1));
        check("b_resp", 128'(bus.axi_lsu_bresp), 128'(eresp));
        check("b_id", 128'(bus.axi_lsu_bid), 128'(id[0]));
        check("b_tag", 128'(bus.axi_lsu_resp_oram_addr), 128'(tag));
        bus.lsu_axi_brdy = 1'b1;
        step();
        bus.lsu_axi_brdy = 1'b0;
        check("b_vld_drop", 128'(bus.axi_lsu_bvld), 128'(0));
    endtask

    // ------------------------------------------------------------- read burst
    // bp_mode: 0 rrdy always high, 1 random rrdy, 2 rrdy pattern 1,0,0,1,1...
    task automatic axi_read(input logic [7:0] id, input logic [9:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input int bp_mode);
        logic [63:0] exp_q [$];
        int   idx = int'(addr[9:3]);
        bit   sup = out_of_bounds(addr, len, burst);
        logic [1:0] eresp = (fmt_err(size, burst) || sup) ? 2'b10 : 2'b00;
        int   t, b, cyc;
        logic r;
        for (int k = 0; k <= int'(len); k++) begin
            exp_q.push_back(sup ? 64'd0 : model[idx]);
            idx = nxt(idx, burst);
        end
        bus.lsu_axi_arid    = id;
        bus.lsu_axi_araddr  = addr;
        bus.lsu_axi_arlen   = len;
        bus.lsu_axi_arburst = burst;
        bus.lsu_axi_arsize  = size;
        bus.lsu_axi_arstr   = 3'($urandom);
        bus.lsu_axi_arvld   = 1'b1;
        t = 0;
        while (!bus.axi_lsu_arrdy && t < BOUND) begin step(); t++; end
        check("ar_wait", 128'(t < BOUND), 128'(1));
        step();
        bus.lsu_axi_arvld = 1'b0;
        b   = 0;
        cyc = 0;
        while (b <= int'(len) && cyc < 4 * BOUND) begin
            case (bp_mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(1, 0));
                default: r = !(cyc == 1 || cyc == 2);
            endcase
            bus.lsu_axi_rrdy = r;
            check("r_vld", 128'(bus.axi_lsu_rvld), 128'(1));
            check("r_data", 128'(bus.axi_lsu_rdata), 128'(exp_q[b]));
            check("r_last", 128'(bus.axi_lsu_rlast), 128'(b == int'(len)));
            check("r_id", 128'(bus.axi_lsu_rid), 128'(id));
            check("r_resp", 128'(bus.axi_lsu_rresp), 128'(eresp));
            step();
            cyc++;
            if (r) b++;
        end
        bus.lsu_axi_rrdy = 1'b0;
        check("r_beats", 128'(b), 128'(int'(len) + 1));
        check("r_vld_drop", 128'(bus.axi_lsu_rvld), 128'(0));
    endtask

    // ------------------------------------------------------------------ main
    initial begin
        logic [9:0] a;
        logic [7:0] l;
        logic [1:0] bu;
        logic [2:0] sz;
        int         la;

        for (int i = 0; i < MEM_WORDS; i++) model[i] = 64'd0;
        bus.lsu_axi_awid = '0;  bus.lsu_axi_awaddr = '0;  bus.lsu_axi_awlen = '0;
        bus.lsu_axi_awsize = '0; bus.lsu_axi_awburst = '0; bus.lsu_axi_awstr = '0;
        bus.lsu_axi_awvld = 1'b0; bus.lsu_axi_oram_addr = '0;
        bus.lsu_axi_wdata = '0; bus.lsu_axi_wstrb = '0; bus.lsu_axi_wlast = 1'b0;
        bus.lsu_axi_wvld = 1'b0; bus.lsu_axi_brdy = 1'b0;
        bus.lsu_axi_arid = '0;  bus.lsu_axi_araddr = '0;  bus.lsu_axi_arlen = '0;
        bus.lsu_axi_arsize = '0; bus.lsu_axi_arburst = '0; bus.lsu_axi_arstr = '0;
        bus.lsu_axi_arvld = 1'b0; bus.lsu_axi_rrdy = 1'b0;

        // Reset state
        step(); step();
        check("reset_outputs", all_outs(), 128'd0);
        rst_n = 1'b1;
        check("rdy_before_first_edge", 128'({bus.axi_lsu_awrdy, bus.axi_lsu_arrdy}), 128'd0);
        step();
        check("rdy_after_first_edge", 128'({bus.axi_lsu_awrdy, bus.axi_lsu_arrdy}), 128'd3);

        // INCR write then read of the same four words
        wd[0] = {8{8'h11}}; wd[1] = {8{8'h22}}; wd[2] = {8{8'h33}}; wd[3] = {8{8'h44}};
        for (int b = 0; b < 4; b++) ws[b] = 8'hFF;
        axi_write(8'h5B, 10'h010, 8'd3, 2'b01, 3'd3, 12'hABC, 3, 0);
        axi_read(8'h33, 10'h010, 8'd3, 2'b01, 3'd3, 0);

        // Byte strobes on word 5
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        axi_write(8'h02, 10'h028, 8'd0, 2'b01, 3'd3, 12'h005, 0, 0);
        wd[0] = 64'h0; ws[0] = 8'h0F;
        axi_write(8'h03, 10'h02D, 8'd0, 2'b01, 3'd3, 12'h006, 0, 0);
        axi_read(8'h44, 10'h028, 8'd0, 2'b01, 3'd3, 0);

        // Early wlast: SLVERR but both beats land
        fill(2, 1'b0);
        axi_write(8'h81, 10'h100, 8'd1, 2'b01, 3'd3, 12'h777, 0, 0);
        axi_read(8'h45, 10'h100, 8'd1, 2'b01, 3'd3, 0);

        // Missing wlast on the final beat
        fill(3, 1'b1);
        axi_write(8'h10, 10'h180, 8'd2, 2'b01, 3'd3, 12'h123, 7, 1);

        // R backpressure during a three-beat read
        axi_read(8'hC7, 10'h180, 8'd2, 2'b01, 3'd3, 2);

        // Concurrent write across the top of memory and read of words 0..1
        fill(2, 1'b0);
        fork
            axi_write(8'h07, 10'h3F8, 8'd1, 2'b01, 3'd3, 12'hFED, 1, 0);
            axi_read(8'h99, 10'h000, 8'd1, 2'b01, 3'd3, 0);
        join
        axi_read(8'h9A, 10'h3F8, 8'd0, 2'b01, 3'd3, 0);
        axi_read(8'h9B, 10'h000, 8'd0, 2'b01, 3'd3, 0);

        // Illegal size / burst encodings
        fill(2, 1'b0);
        axi_write(8'h20, 10'h200, 8'd1, 2'b01, 3'd2, 12'h0AA, 1, 0);
        axi_read(8'h21, 10'h200, 8'd1, 2'b10, 3'd3, 0);
        axi_read(8'h22, 10'h200, 8'd1, 2'b01, 3'd3, 1);

        // FIXED burst with random strobes
        fill(4, 1'b1);
        axi_write(8'h30, 10'h0C0, 8'd3, 2'b00, 3'd3, 12'h0BB, 3, 2);
        axi_read(8'h31, 10'h0C0, 8'd2, 2'b00, 3'd3, 1);

        // Randomized write/read pairs
        for (int n = 0; n < 24; n++) begin
            a  = 10'($urandom);
            l  = 8'($urandom_range(7, 0));
            bu = ($urandom_range(3, 0) == 0) ? 2'b00 : 2'b01;
            sz = ($urandom_range(9, 0) == 0) ? 3'd2 : 3'd3;
            la = ($urandom_range(7, 0) == 0) ? int'($urandom_range(int'(l), 0)) : int'(l);
            fill(int'(l) + 1, 1'($urandom_range(1, 0)));
            axi_write(8'($urandom), a, l, bu, sz, 12'($urandom), la, 2);
            if ($urandom_range(1, 0) == 1) a = 10'($urandom);
            axi_read(8'($urandom), a, 8'($urandom_range(7, 0)), bu, 3'd3, 1);
        end

        // Reset in the middle of a write burst
        fill(4, 1'b0);
        bus.lsu_axi_awid = 8'h01; bus.lsu_axi_awaddr = 10'h020; bus.lsu_axi_awlen = 8'd3;
        bus.lsu_axi_awburst = 2'b01; bus.lsu_axi_awsize = 3'd3; bus.lsu_axi_oram_addr = 12'h555;
        bus.lsu_axi_awvld = 1'b1;
        step();
        bus.lsu_axi_awvld = 1'b0;
        bus.lsu_axi_wdata = wd[0]; bus.lsu_axi_wstrb = 8'hFF; bus.lsu_axi_wvld = 1'b1;
        step();
        bus.lsu_axi_wdata = wd[1];
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", all_outs(), 128'd0);
        bus.lsu_axi_wvld = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) model[i] = 64'd0;
        step();
        check("held_reset_outputs", all_outs(), 128'd0);
        rst_n = 1'b1;
        check("awrdy_before_edge", 128'(bus.axi_lsu_awrdy), 128'd0);
        step();
        check("awrdy_first_cycle", 128'(bus.axi_lsu_awrdy), 128'd1);
        axi_read(8'h60, 10'h020, 8'd3, 2'b01, 3'd3, 0);
        axi_read(8'h61, 10'h3F8, 8'd1, 2'b01, 3'd3, 0);
        fill(2, 1'b1);
        axi_write(8'h62, 10'h020, 8'd1, 2'b01, 3'd3, 12'h0CD, 1, 0);
        axi_read(8'h63, 10'h020, 8'd1, 2'b01, 3'd3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
